// File: rtl/rr_arb_fifo.sv
// Four-requester round-robin arbiter feeding a first-word-fall-through FIFO.
// Latency: req sampled in IDLE -> grant/push next cycle -> word visible on data_out one cycle later.
// Backpressure: a full FIFO parks the arbiter in WAIT_SPACE; requesters hold req until granted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[3:0]            per-requester request, held until granted
//   req_data            lane i at [i*WIDTH +: WIDTH]
//   flush               drop FIFO contents (only with RR_ARB_FIFO_FLUSH_EN defined)
//   pop                 consumer read strobe
//   grant[3:0]          registered one-hot-or-zero grant
//   push, data_in       FIFO write strobe and the word being written
//   data_out            FIFO head, 0 when empty
//   full, empty, count  occupancy status
//   state[2:0]          arbiter FSM state
// Optional feature macro: RR_ARB_FIFO_FLUSH_EN (flush port active, FLUSH state built).

module rr_arb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             req,
  input  logic [4*WIDTH-1:0]     req_data,
  input  logic                   flush,
  input  logic                   pop,
  output logic [3:0]             grant,
  output logic                   push,
  output logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [2:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    GRANT      = 3'b001,
    WRITE      = 3'b010,
    FLUSH      = 3'b011,
    WAIT_SPACE = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q;
  logic [1:0]       last_q;
  logic             load_grant;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             flush_act;
  logic             in_flush;
  logic             pop_acc;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count_q;

`ifdef RR_ARB_FIFO_FLUSH_EN
  assign flush_act = flush;
  assign in_flush  = (state_q == FLUSH);
`else
  // Flush has no effect in this build; the port stays for pin compatibility.
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
  assign in_flush     = 1'b0;
`endif

  // Round-robin search: start one past the last winner and wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'(k + 1);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_act) begin
          state_d = FLUSH;
        end else if (win_vld && !full) begin
          state_d    = GRANT;
          load_grant = 1'b1;
        end else if (win_vld) begin
          state_d = WAIT_SPACE;
        end
      end
      GRANT:      state_d = WRITE;
      WRITE:      state_d = IDLE;
      WAIT_SPACE: begin
        if (flush_act) begin
          state_d = FLUSH;
        end else if (!full || !(|req)) begin
          state_d = IDLE;
        end
      end
`ifdef RR_ARB_FIFO_FLUSH_EN
      FLUSH:      state_d = IDLE;
`endif
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      if (load_grant) begin
        grant_q <= 4'b0001 << win_idx;
        last_q  <= win_idx;
      end else if (state_q == GRANT) begin
        grant_q <= 4'b0000;
      end
    end
  end

  // The granted requester is still holding its lane, so the grant selects it directly.
  always_comb begin
    data_in = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        data_in = data_in | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign push    = (state_q == GRANT);
  assign pop_acc = pop && !empty && !in_flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // push is never issued while full, so count stays within 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (in_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_acc};
    end
  end

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign grant    = grant_q;
  assign state    = state_q;

endmodule

// File: tb/tb_rr_arb_fifo.sv
module tb_rr_arb_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int S_IDLE = 0, S_GRANT = 1, S_WRITE = 2, S_FLUSH = 3, S_WAIT = 4;
`ifdef RR_ARB_FIFO_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] req_data;
  logic               flush;
  logic               pop;
  logic [3:0]         grant;
  logic               push;
  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   data_out;
  logic               full;
  logic               empty;
  logic [4:0]         count;
  logic [2:0]         state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: occupancy as a queue of words, arbiter phase, last winner.
  int               m_state;
  int               m_last;
  int               m_lane;
  logic [WIDTH-1:0] mq[$];
  logic [3:0]       r_now;
  logic             f_now;
  logic             p_now;
  logic [WIDTH-1:0] ld [4];

  rr_arb_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .flush(flush), .pop(pop),
    .grant(grant), .push(push), .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .count(count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_data = '0; flush = 1'b0; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input int lane, input logic [WIDTH-1:0] d);
    bit found = 0;
    req_data[lane*WIDTH +: WIDTH] = d;
    req[lane] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (push) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL push_word timeout: lane %0d got no push in 8 cycles", lane); end
    tick();
    req[lane] = 1'b0;
    tick();
  endtask

  function automatic int rr_pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_last = 3; m_lane = 0; mq.delete();
    r_now = '0; f_now = 1'b0; p_now = 1'b0;
    for (int i = 0; i < 4; i++) ld[i] = '0;
  endtask

  // Effects of one clock edge, using the inputs that were present at that edge.
  task automatic model_edge();
    int nxt;
    bit fe;
    bit pop_ok;
    bit fullb;
    fullb  = (mq.size() == DEPTH);
    fe     = FLUSH_EN && f_now;
    pop_ok = p_now && (mq.size() != 0) && (m_state != S_FLUSH);
    nxt    = m_state;
    case (m_state)
      S_IDLE: begin
        if (fe) nxt = S_FLUSH;
        else if (r_now != 0 && !fullb) begin
          nxt = S_GRANT; m_lane = rr_pick(m_last, r_now); m_last = m_lane;
        end else if (r_now != 0) nxt = S_WAIT;
      end
      S_GRANT: nxt = S_WRITE;
      S_WRITE: nxt = S_IDLE;
      S_WAIT: begin
        if (fe) nxt = S_FLUSH;
        else if (!fullb || r_now == 0) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (m_state == S_FLUSH) mq.delete();
    else begin
      if (pop_ok) void'(mq.pop_front());
      if (m_state == S_GRANT) mq.push_back(ld[m_lane]);
    end
    m_state = nxt;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) tick();
    checks++; if (grant !== 4'b0)  begin errors++; $display("FAIL reset grant: got %b want 0000", grant); end
    checks++; if (push !== 1'b0)   begin errors++; $display("FAIL reset push: got %b want 0", push); end
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset state: got %b want 000", state); end
    checks++; if (count !== 5'd0)  begin errors++; $display("FAIL reset count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset full: got %b want 0", full); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset data_out: got %h want 0", data_out); end
    checks++; if (data_in !== 32'h0)  begin errors++; $display("FAIL reset data_in: got %h want 0", data_in); end
  endtask

  task automatic test_single_grant();
    req_data[31:0] = 32'hA5A5_0001;
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single grant: got %b want 0001", grant); end
    checks++; if (push !== 1'b1) begin errors++; $display("FAIL single push: got %b want 1", push); end
    checks++; if (data_in !== 32'hA5A5_0001) begin errors++; $display("FAIL single data_in: got %h want a5a50001", data_in); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single count before write: got %0d want 0", count); end
    tick();
    req = 4'b0000;
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL single write state: got %b want 010", state); end
    checks++; if (grant !== 4'b0 || push !== 1'b0) begin errors++; $display("FAIL single write grant/push: got %b/%b want 0000/0", grant, push); end
    checks++; if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL single count/empty: got %0d/%b want 1/0", count, empty); end
    checks++; if (data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL single data_out: got %h want a5a50001", data_out); end
    tick();
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL single back to idle: got %b want 000", state); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || data_out !== 32'h0) begin
      errors++; $display("FAIL single drain: got count %0d empty %b data_out %h want 0/1/0", count, empty, data_out);
    end
  endtask

  task automatic test_rr_order();
    int last_push = -1;
    logic [3:0] exp_g;
    logic [WIDTH-1:0] exp_d;
    bit found;
    apply_reset();
    for (int i = 0; i < 4; i++) req_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (push) begin found = 1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL rr timeout: no push for lane %0d", g); end
      exp_g = 4'b0001;
      exp_g = exp_g << g;
      exp_d = 32'h1000_0000 + 32'(g);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr order %0d: got %b want %b", g, grant, exp_g); end
      checks++; if (data_in !== exp_d) begin errors++; $display("FAIL rr data_in %0d: got %h want %h", g, data_in, exp_d); end
      if (last_push >= 0) begin
        checks++; if (cyc - last_push != 3) begin errors++; $display("FAIL rr spacing %0d: got %0d cycles want 3", g, cyc - last_push); end
      end
      last_push = cyc;
      tick();
      req[g] = 1'b0;
    end
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL rr count: got %0d want 4", count); end
  endtask

  task automatic test_full_wait();
    bit reached = 0;
    req_data[2*WIDTH +: WIDTH] = 32'hC0C0_0004;
    req = 4'b0100;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (count == 5'd16) begin reached = 1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL fill timeout: count %0d want 16", count); end
    repeat (3) tick();
    checks++; if (state !== 3'b100) begin errors++; $display("FAIL full state: got %b want 100", state); end
    checks++; if (push !== 1'b0 || full !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL full status: got push %b full %b count %0d want 0/1/16", push, full, count);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (count !== 5'd15 || full !== 1'b0) begin errors++; $display("FAIL pop from full: got count %0d full %b want 15/0", count, full); end
    checks++; if (data_out !== 32'h1000_0001) begin errors++; $display("FAIL head after pop: got %h want 10000001", data_out); end
    tick();
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL wait exit: got %b want 000", state); end
    tick();
    checks++; if (state !== 3'b001 || push !== 1'b1 || grant !== 4'b0100) begin
      errors++; $display("FAIL refill grant: got state %b push %b grant %b want 001/1/0100", state, push, grant);
    end
    tick();
    req = 4'b0000;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL refill count: got %0d want 16", count); end
    tick();
  endtask

  task automatic test_pop_empty_and_simultaneous();
    pop = 1'b1;
    repeat (16) tick();
    pop = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain: got count %0d empty %b want 0/1", count, empty); end
    pop = 1'b1;
    repeat (3) tick();
    pop = 1'b0;
    checks++; if (count !== 5'd0 || data_out !== 32'h0) begin errors++; $display("FAIL pop empty: got count %0d data_out %h want 0/0", count, data_out); end
    push_word(1, 32'h5555_0001);
    checks++; if (count !== 5'd1 || data_out !== 32'h5555_0001) begin
      errors++; $display("FAIL pointers after empty pop: got count %0d head %h want 1/55550001", count, data_out);
    end
    for (int i = 0; i < 4; i++) push_word(i, 32'h5555_0002 + 32'(i));
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL count before simultaneous: got %0d want 5", count); end
    req_data[3*WIDTH +: WIDTH] = 32'h5555_0006;
    req = 4'b1000;
    tick();
    pop = 1'b1;
    checks++; if (push !== 1'b1) begin errors++; $display("FAIL simultaneous push: got %b want 1", push); end
    tick();
    pop = 1'b0;
    req = 4'b0000;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL simultaneous count: got %0d want 5", count); end
    checks++; if (data_out !== 32'h5555_0002) begin errors++; $display("FAIL simultaneous head: got %h want 55550002", data_out); end
    tick();
  endtask

  task automatic test_flush();
    push_word(0, 32'h5555_0007);
    push_word(1, 32'h5555_0008);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL flush setup count: got %0d want 7", count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef RR_ARB_FIFO_FLUSH_EN
    checks++; if (state !== 3'b011) begin errors++; $display("FAIL flush state: got %b want 011", state); end
    tick();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || state !== 3'b000) begin
      errors++; $display("FAIL flush result: got count %0d empty %b state %b want 0/1/000", count, empty, state);
    end
`else
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL flush ignored state: got %b want 000", state); end
    tick();
    checks++; if (count !== 5'd7 || empty !== 1'b0) begin errors++; $display("FAIL flush ignored count: got %0d empty %b want 7/0", count, empty); end
`endif
  endtask

  task automatic test_random();
    logic [3:0]       exp_g;
    logic [WIDTH-1:0] exp_din, exp_dout;
    logic [2:0]       exp_st;
    int               pop_div;
    apply_reset();
    model_reset();
    for (int it = 0; it < 2400 && errors < 30; it++) begin
      tick();
      model_edge();
      for (int i = 0; i < 4; i++) begin
        if (m_state == S_WRITE && i == m_lane) r_now[i] = 1'b0;
        else if (!r_now[i] && $urandom_range(0, 3) == 0) begin r_now[i] = 1'b1; ld[i] = $urandom; end
      end
      pop_div = ((it / 300) % 2 == 0) ? 7 : 1;
      p_now = ($urandom_range(0, pop_div) == 0);
      f_now = ($urandom_range(0, 127) == 0);
      req = r_now; flush = f_now; pop = p_now;
      for (int i = 0; i < 4; i++) req_data[i*WIDTH +: WIDTH] = ld[i];
      #1;
      exp_g = 4'b0;
      exp_din = '0;
      if (m_state == S_GRANT) begin exp_g[m_lane] = 1'b1; exp_din = ld[m_lane]; end
      exp_dout = (mq.size() != 0) ? mq[0] : '0;
      exp_st = m_state[2:0];
      checks++; if (state !== exp_st) begin errors++; $display("FAIL rand state @%0d: got %b want %b", cyc, state, exp_st); end
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rand grant @%0d: got %b want %b", cyc, grant, exp_g); end
      checks++; if (push !== (m_state == S_GRANT)) begin errors++; $display("FAIL rand push @%0d: got %b", cyc, push); end
      checks++; if (data_in !== exp_din) begin errors++; $display("FAIL rand data_in @%0d: got %h want %h", cyc, data_in, exp_din); end
      checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL rand count @%0d: got %0d want %0d", cyc, count, mq.size()); end
      checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rand empty/full @%0d: got %b/%b size %0d", cyc, empty, full, mq.size());
      end
      checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL rand data_out @%0d: got %h want %h", cyc, data_out, exp_dout); end
      checks++; if ((grant & ~req) !== 4'b0) begin errors++; $display("FAIL rand grant without req @%0d: grant %b req %b", cyc, grant, req); end
      if (it == 1000) begin
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'b000 || count !== 5'd0 || grant !== 4'b0 || push !== 1'b0) begin
          errors++; $display("FAIL async reset: got state %b count %0d grant %b push %b want 000/0/0000/0", state, count, grant, push);
        end
        rst_n = 1'b1;
        model_reset();
        req = '0; flush = 1'b0; pop = 1'b0; req_data = '0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; flush = 1'b0; pop = 1'b0;
    test_reset();
    test_single_grant();
    test_rr_order();
    test_full_wait();
    test_pop_empty_and_simultaneous();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
